// File: rtl/reg8bit_register.sv
// -----------------------------------------------------------------------------
// reg8bit_register
//
// Parallel-load data register. On a rising clock edge with enable high, the
// word on D is captured into Q; with enable low, Q holds its contents. Q is
// always a registered value: D and enable never reach Q combinationally.
// An asynchronous active-low reset forces Q to RESET_VAL immediately and keeps
// it there, ignoring clock edges, for as long as reset is low.
//
// Optional feature (macro REG8BIT_REGISTER_PARITY_EN):
//   When defined, an extra output q_parity carries the even-parity bit of Q
//   (1 when Q holds an odd number of ones). It is registered alongside Q, so it
//   always equals ^Q with no extra latency. When undefined, the port and its
//   logic are absent and all other behaviour is unchanged.
//
// Parameters:
//   WIDTH      data width of D and Q
//   RESET_VAL  value forced onto Q while reset is asserted
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous reset, active low (0 = asserted)
//   enable    in   1      level-sensitive load enable, sampled on rising clk
//   D         in   WIDTH  parallel data input
//   Q         out  WIDTH  registered data output
//   q_parity  out  1      parity of Q (only with REG8BIT_REGISTER_PARITY_EN)
// -----------------------------------------------------------------------------
module reg8bit_register #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
`ifdef REG8BIT_REGISTER_PARITY_EN
   ,
   output logic             q_parity
`endif
);

   // Data register: reset dominates, then enable selects load or hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Q <= RESET_VAL;
      end else if (enable) begin
         Q <= D;
      end
   end

`ifdef REG8BIT_REGISTER_PARITY_EN
   function automatic logic parity_of(input logic [WIDTH-1:0] word);
      parity_of = ^word;
   endfunction

   // Parity is computed from D at load time rather than from Q afterwards,
   // so it changes on the same edge as Q and never lags it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_parity <= parity_of(RESET_VAL);
      end else if (enable) begin
         q_parity <= parity_of(D);
      end
   end
`endif

endmodule

// File: tb/tb_reg8bit_register.sv
// -----------------------------------------------------------------------------
// tb_reg8bit_register
//
// Directed bench for reg8bit_register (default parameters). Inputs change on
// the falling clock edge; outputs are sampled on the falling edge or a short
// delay after an asynchronous reset change, never at the rising edge.
// Parity checks are included when REG8BIT_REGISTER_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_reg8bit_register;

   localparam int WIDTH = 8;

   logic             clk;
   logic             reset;
   logic             enable;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
`ifdef REG8BIT_REGISTER_PARITY_EN
   logic             q_parity;
`endif

   int vectors;
   int miscompares;

   reg8bit_register #(
      .WIDTH    (WIDTH),
      .RESET_VAL(8'h00)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .D       (D),
      .Q       (Q)
`ifdef REG8BIT_REGISTER_PARITY_EN
      ,
      .q_parity(q_parity)
`endif
   );

   // 10-unit clock: rising edges at 5, 15, 25 ...; falling at 10, 20, 30 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] observed,
                        input logic [7:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
      end
   endtask

   // Advance to the next falling edge (one rising edge has just passed).
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      // Test 1: reset held with enable=1 and D=0xFF; edges must be ignored.
      reset  = 1'b0;
      enable = 1'b1;
      D      = 8'hFF;
      #1;
      check("reset_async", Q, 8'h00);
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_hold_edges", Q, 8'h00);
      end
      // Release reset with enable low: Q stays at reset value.
      enable = 1'b0;
      reset  = 1'b1;
      #1;
      check("reset_release", Q, 8'h00);
      step();
      check("post_release_hold", Q, 8'h00);

      // Test 2: single load.
      enable = 1'b1;
      D      = 8'hAA;
      step();
      check("load_AA", Q, 8'hAA);

      // Test 3: hold while D changes.
      enable = 1'b0;
      D      = 8'h55;
      step();
      check("hold_AA_1", Q, 8'hAA);
      step();
      check("hold_AA_2", Q, 8'hAA);

      // Test 4: load then hold.
      enable = 1'b1;
      D      = 8'hCC;
      step();
      check("load_CC", Q, 8'hCC);
      enable = 1'b0;
      D      = 8'hF0;
      step();
      check("hold_CC", Q, 8'hCC);

      // Test 5: reset asserted mid-cycle (clk low), held across an enabled edge.
      reset = 1'b0;
      #1;
      check("midcycle_reset", Q, 8'h00);
      enable = 1'b1;
      D      = 8'h3C;
      step();
      check("reset_blocks_load", Q, 8'h00);

      // Release and verify back-to-back loads capture each word.
      reset = 1'b1;
      step();
      check("b2b_load_3C", Q, 8'h3C);
      D = 8'h81;
      step();
      check("b2b_load_81", Q, 8'h81);
      D = 8'h7E;
      step();
      check("b2b_load_7E", Q, 8'h7E);

      // Test 6: parity-oriented loads (Q checked in every build).
      D = 8'h07;
      step();
      check("load_07", Q, 8'h07);
`ifdef REG8BIT_REGISTER_PARITY_EN
      check("parity_07", {7'b0, q_parity}, 8'h01);
`endif
      D = 8'hAA;
      step();
      check("load_AA_again", Q, 8'hAA);
`ifdef REG8BIT_REGISTER_PARITY_EN
      check("parity_AA", {7'b0, q_parity}, 8'h00);
`endif
      // Load odd-parity word then reset: parity must return to 0.
      D = 8'h01;
      step();
      check("load_01", Q, 8'h01);
`ifdef REG8BIT_REGISTER_PARITY_EN
      check("parity_01", {7'b0, q_parity}, 8'h01);
`endif
      reset = 1'b0;
      #1;
      check("final_reset", Q, 8'h00);
`ifdef REG8BIT_REGISTER_PARITY_EN
      check("parity_reset", {7'b0, q_parity}, 8'h00);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
